// File: rtl/error_event_logger_if.sv
// Event-in / record-out bundle for error_event_logger.
// The master side drives events, clear and out_ready; the slave side (the logger) drives records and status.
interface error_event_logger_if #(
    parameter int NUM_SOURCES = 4,
    parameter int CODE_WIDTH  = 8,
    parameter int TS_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int OVF_WIDTH   = 16
);
    localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                              clear;
    logic [NUM_SOURCES-1:0]            ev_valid;
    logic [NUM_SOURCES-1:0]            ev_severity;
    logic [NUM_SOURCES*CODE_WIDTH-1:0] ev_code;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_severity;
    logic [SRC_W-1:0]                  out_source;
    logic [CODE_WIDTH-1:0]             out_code;
    logic [TS_WIDTH-1:0]               out_timestamp;
    logic [CNT_W-1:0]                  fifo_count;
    logic [OVF_WIDTH-1:0]              overflow_count;
    logic                              error_sticky;

    modport master (
        output clear, ev_valid, ev_severity, ev_code, out_ready,
        input  out_valid, out_severity, out_source, out_code, out_timestamp,
               fifo_count, overflow_count, error_sticky
    );

    modport slave (
        input  clear, ev_valid, ev_severity, ev_code, out_ready,
        output out_valid, out_severity, out_source, out_code, out_timestamp,
               fifo_count, overflow_count, error_sticky
    );
endinterface

// File: rtl/error_event_logger.sv
// Timestamped event recorder: per-source pending slots, fixed-priority arbiter,
// show-ahead FIFO with valid/ready drain, saturating drop counter and sticky error flag.
module error_event_logger #(
    parameter int NUM_SOURCES = 4,
    parameter int CODE_WIDTH  = 8,
    parameter int TS_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int OVF_WIDTH   = 16
) (
    input logic               clk,
    input logic               rst_n,
    error_event_logger_if.slave bus
);
    localparam int SRC_W  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int DROP_W = $clog2(NUM_SOURCES + 1);
    localparam int OW1    = OVF_WIDTH + 1;
    localparam int REC_W  = 1 + SRC_W + CODE_WIDTH + TS_WIDTH;

    logic [TS_WIDTH-1:0]   r_ts;
    logic [NUM_SOURCES-1:0] r_slot_full;
    logic [NUM_SOURCES-1:0] r_slot_sev;
    logic [CODE_WIDTH-1:0] r_slot_code [NUM_SOURCES];
    logic [TS_WIDTH-1:0]   r_slot_ts   [NUM_SOURCES];
    logic [REC_W-1:0]      r_mem       [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [OVF_WIDTH-1:0]  r_ovf;
    logic                  r_sticky;

    logic                   w_grant_valid;
    logic [SRC_W-1:0]       w_grant_idx;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_out_valid;
    logic [NUM_SOURCES-1:0] w_capture;
    logic [DROP_W-1:0]      w_drop_n;
    logic [OW1-1:0]         w_ovf_sum;
    logic [REC_W-1:0]       w_head;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (r_slot_full[i]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = SRC_W'(i);
            end
        end
    end

    assign w_push      = w_grant_valid && (r_count < CNT_W'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    // A slot accepts a new event if empty or being drained into the FIFO on this edge.
    always_comb begin
        w_capture = '0;
        w_drop_n  = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (bus.ev_valid[i]) begin
                if (!r_slot_full[i] || (w_push && (w_grant_idx == SRC_W'(i))))
                    w_capture[i] = 1'b1;
                else
                    w_drop_n = w_drop_n + DROP_W'(1);
            end
        end
    end

    assign w_ovf_sum = {1'b0, r_ovf} + OW1'(w_drop_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts        <= '0;
            r_slot_full <= '0;
            r_slot_sev  <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                r_slot_code[i] <= '0;
                r_slot_ts[i]   <= '0;
            end
        end else if (bus.clear) begin
            r_ts        <= '0;
            r_slot_full <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (w_capture[i]) begin
                    r_slot_full[i] <= 1'b1;
                    r_slot_sev[i]  <= bus.ev_severity[i];
                    r_slot_code[i] <= bus.ev_code[i*CODE_WIDTH +: CODE_WIDTH];
                    r_slot_ts[i]   <= r_ts;
                end else if (w_push && (w_grant_idx == SRC_W'(i))) begin
                    r_slot_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
            r_sticky <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            r_ovf <= w_ovf_sum[OVF_WIDTH] ? '1 : w_ovf_sum[OVF_WIDTH-1:0];
            if (|(bus.ev_valid & bus.ev_severity)) r_sticky <= 1'b1;
        end
    end

    // Storage is not reset; outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (w_push && !bus.clear)
            r_mem[r_wr_ptr] <= {r_slot_sev[w_grant_idx], w_grant_idx,
                                r_slot_code[w_grant_idx], r_slot_ts[w_grant_idx]};
    end

    assign w_head = r_mem[r_rd_ptr];

    assign bus.out_valid      = w_out_valid;
    assign bus.out_severity   = w_out_valid & w_head[REC_W-1];
    assign bus.out_source     = w_out_valid ? w_head[REC_W-2 -: SRC_W] : '0;
    assign bus.out_code       = w_out_valid ? w_head[TS_WIDTH +: CODE_WIDTH] : '0;
    assign bus.out_timestamp  = w_out_valid ? w_head[TS_WIDTH-1:0] : '0;
    assign bus.fifo_count     = r_count;
    assign bus.overflow_count = r_ovf;
    assign bus.error_sticky   = r_sticky;
endmodule
